// File: rtl/lane_permute_ctrl.sv
// Slice-by-slice permutation engine: copies an N x N cell array from a source region
// to a destination region of a single-port memory, remapping (i,j) -> (j, (A*i+B*j) mod N) or transposing.
module lane_permute_ctrl #(
    parameter int N        = 5,
    parameter int NW       = 3,
    parameter int SLICES   = 64,
    parameter int SW       = 6,
    parameter int CW       = 3,
    parameter int DW       = 1,
    parameter int AW       = 12,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 2048
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [CW-1:0] coef_a,
    input  logic [CW-1:0] coef_b,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] slice_idx,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [3:0]    dbg_state
);

    // Handshake: start is a level request honoured only in IDLE (mode/coefs captured on
    // that same edge); done is a one-cycle pulse, and busy covers LOAD through DONE.
    localparam int TW = CW + NW + 1;

    localparam logic [AW-1:0] L_SRC   = AW'(SRC_BASE);
    localparam logic [AW-1:0] L_DST   = AW'(DST_BASE);
    localparam logic [AW-1:0] L_NN    = AW'(N * N);
    localparam logic [AW-1:0] L_N_A   = AW'(N);
    localparam logic [TW-1:0] L_N_T   = TW'(N);
    localparam logic [NW-1:0] L_NM1   = NW'(N - 1);
    localparam logic [SW-1:0] L_SLAST = SW'(SLICES - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_CALC   = 4'd2,
        S_REDUCE = 4'd3,
        S_READ   = 4'd4,
        S_WAIT   = 4'd5,
        S_WRITE  = 4'd6,
        S_ADV    = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic          r_mode;
    logic [CW-1:0] r_a;
    logic [CW-1:0] r_b;
    logic [NW-1:0] r_i;
    logic [NW-1:0] r_j;
    logic [SW-1:0] r_slice;
    logic [TW-1:0] r_t;
    logic [NW-1:0] r_di;
    logic [NW-1:0] r_dj;
    logic [DW-1:0] r_data;

    logic          w_last_j;
    logic          w_last_i;
    logic          w_last_slice;
    logic          w_t_ge_n;
    logic [TW-1:0] w_t_calc;
    logic [AW-1:0] w_src_addr;
    logic [AW-1:0] w_dst_addr;

    assign w_last_j     = (r_j == L_NM1);
    assign w_last_i     = (r_i == L_NM1);
    assign w_last_slice = (r_slice == L_SLAST);
    assign w_t_ge_n     = (r_t >= L_N_T);

    // TW is wide enough for A*i + B*j, so the raw sum never wraps before reduction.
    assign w_t_calc = TW'(r_a) * TW'(r_i) + TW'(r_b) * TW'(r_j);

    assign w_src_addr = L_SRC + AW'(r_slice) * L_NN + AW'(r_i) * L_N_A + AW'(r_j);
    assign w_dst_addr = L_DST + AW'(r_slice) * L_NN + AW'(r_di) * L_N_A + AW'(r_dj);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = start ? S_LOAD : S_IDLE;
            S_LOAD:   w_next = S_CALC;
            S_CALC:   w_next = r_mode ? S_READ : S_REDUCE;
            S_REDUCE: w_next = w_t_ge_n ? S_REDUCE : S_READ;
            S_READ:   w_next = S_WAIT;
            S_WAIT:   w_next = S_WRITE;
            S_WRITE:  w_next = S_ADV;
            S_ADV:    w_next = (w_last_j && w_last_i && w_last_slice) ? S_DONE : S_CALC;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_slice <= '0;
            r_t     <= '0;
            r_di    <= '0;
            r_dj    <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode <= mode;
                        r_a    <= coef_a;
                        r_b    <= coef_b;
                    end
                end
                S_LOAD: begin
                    r_i     <= '0;
                    r_j     <= '0;
                    r_slice <= '0;
                    r_t     <= '0;
                end
                S_CALC: begin
                    if (r_mode) begin
                        r_di <= r_j;
                        r_dj <= r_i;
                    end else begin
                        r_t <= w_t_calc;
                    end
                end
                S_REDUCE: begin
                    // One subtraction per cycle; the exit cycle publishes the reduced column.
                    if (w_t_ge_n) begin
                        r_t <= r_t - L_N_T;
                    end else begin
                        r_di <= r_j;
                        r_dj <= r_t[NW-1:0];
                    end
                end
                S_WAIT: begin
                    r_data <= mem_rdata;
                end
                S_ADV: begin
                    if (w_last_j) begin
                        r_j <= '0;
                        if (w_last_i) begin
                            r_i     <= '0;
                            r_slice <= w_last_slice ? '0 : r_slice + 1'b1;
                        end else begin
                            r_i <= r_i + 1'b1;
                        end
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Every output is a decode of registered state, so reset clears them immediately.
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign mem_rd    = (r_state == S_READ);
    assign mem_wr    = (r_state == S_WRITE);
    assign mem_addr  = (r_state == S_READ)  ? w_src_addr :
                       (r_state == S_WRITE) ? w_dst_addr : '0;
    assign mem_wdata = (r_state == S_WRITE) ? r_data : '0;
    assign slice_idx = r_slice;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_lane_permute_ctrl.sv
// Directed bench for lane_permute_ctrl: three instances (N=5 coefficient map, N=1, N=4 transpose)
// each backed by a behavioural single-port memory with one-cycle read latency.
module tb_lane_permute_ctrl;

    localparam int AW  = 12;
    localparam int DW  = 8;
    localparam int NW  = 3;
    localparam int SW  = 2;
    localparam int CW  = 3;
    localparam int DST = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start_r [3];
    logic          mode_r  [3];
    logic [CW-1:0] a_r     [3];
    logic [CW-1:0] b_r     [3];
    logic          busy_w  [3];
    logic          done_w  [3];
    logic          rd_w    [3];
    logic          wr_w    [3];
    logic [SW-1:0] slice_w [3];
    logic [AW-1:0] addr_w  [3];
    logic [DW-1:0] wdata_w [3];
    logic [DW-1:0] rdata_r [3];
    logic [3:0]    st_w    [3];

    logic [DW-1:0] mem [3][4096];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    lane_permute_ctrl #(.N(5), .NW(NW), .SLICES(4), .SW(SW), .CW(CW), .DW(DW), .AW(AW),
                        .SRC_BASE(0), .DST_BASE(DST)) u_dut5 (
        .clk(clk), .rst(rst), .start(start_r[0]), .mode(mode_r[0]), .coef_a(a_r[0]), .coef_b(b_r[0]),
        .busy(busy_w[0]), .done(done_w[0]), .slice_idx(slice_w[0]), .mem_addr(addr_w[0]),
        .mem_rd(rd_w[0]), .mem_wr(wr_w[0]), .mem_wdata(wdata_w[0]), .mem_rdata(rdata_r[0]),
        .dbg_state(st_w[0]));

    lane_permute_ctrl #(.N(1), .NW(NW), .SLICES(4), .SW(SW), .CW(CW), .DW(DW), .AW(AW),
                        .SRC_BASE(0), .DST_BASE(DST)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_r[1]), .mode(mode_r[1]), .coef_a(a_r[1]), .coef_b(b_r[1]),
        .busy(busy_w[1]), .done(done_w[1]), .slice_idx(slice_w[1]), .mem_addr(addr_w[1]),
        .mem_rd(rd_w[1]), .mem_wr(wr_w[1]), .mem_wdata(wdata_w[1]), .mem_rdata(rdata_r[1]),
        .dbg_state(st_w[1]));

    lane_permute_ctrl #(.N(4), .NW(NW), .SLICES(1), .SW(SW), .CW(CW), .DW(DW), .AW(AW),
                        .SRC_BASE(0), .DST_BASE(DST)) u_dut4 (
        .clk(clk), .rst(rst), .start(start_r[2]), .mode(mode_r[2]), .coef_a(a_r[2]), .coef_b(b_r[2]),
        .busy(busy_w[2]), .done(done_w[2]), .slice_idx(slice_w[2]), .mem_addr(addr_w[2]),
        .mem_rd(rd_w[2]), .mem_wr(wr_w[2]), .mem_wdata(wdata_w[2]), .mem_rdata(rdata_r[2]),
        .dbg_state(st_w[2]));

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rd_w[d]) rdata_r[d] <= mem[d][addr_w[d]];
            if (wr_w[d]) mem[d][addr_w[d]] = wdata_w[d];
        end
    end

    // Monitor for the selected instance, sampled on the falling edge.
    int            mon_sel = 0;
    logic [AW-1:0] rd_q[$];
    logic [AW-1:0] wr_q[$];
    int            rd_cyc_q[$];
    int            load_cyc_q[$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            fall_cyc = 0;
    int            both_cnt = 0;
    logic          busy_prev = 1'b0;

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rd_w[d] && wr_w[d]) both_cnt++;
        end
        if (rd_w[mon_sel]) begin
            rd_q.push_back(addr_w[mon_sel]);
            rd_cyc_q.push_back(cyc);
        end
        if (wr_w[mon_sel]) wr_q.push_back(addr_w[mon_sel]);
        if (done_w[mon_sel]) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy_w[mon_sel] && !busy_prev) load_cyc_q.push_back(cyc);
        if (!busy_w[mon_sel] && busy_prev) fall_cyc = cyc;
        busy_prev = busy_w[mon_sel];
    end

    task automatic clear_mon(input int d);
        mon_sel = d;
        rd_q.delete();
        wr_q.delete();
        rd_cyc_q.delete();
        load_cyc_q.delete();
        done_cnt  = 0;
        done_cyc  = 0;
        fall_cyc  = 0;
        busy_prev = 1'b0;
    endtask

    task automatic pulse_start(input int d, input logic m, input int a, input int b);
        @(negedge clk);
        mode_r[d]  = m;
        a_r[d]     = CW'(a);
        b_r[d]     = CW'(b);
        start_r[d] = 1'b1;
        @(negedge clk);
        start_r[d] = 1'b0;
    endtask

    task automatic wait_done_cnt(input int target, input int bound, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (done_cnt < target) begin
            if (n >= bound) begin
                ok = 1'b0;
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic preload_dut5();
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 25; k++) begin
                mem[0][s*25 + k]       = DW'(s*25 + k + 16);
                mem[0][DST + s*25 + k] = 8'hEE;
            end
    endtask

    function automatic int count_bad_map(input int a, input int b);
        int bad = 0;
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    if (mem[0][DST + s*25 + j*5 + ((a*i + b*j) % 5)] !== DW'(s*25 + i*5 + j + 16))
                        bad++;
        return bad;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start_r[d] = 1'b0;
            mode_r[d]  = 1'b0;
            a_r[d]     = '0;
            b_r[d]     = '0;
        end
        repeat (2) @(negedge clk);
        checks++; if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy_w[0]); end
        checks++; if (done_w[0] !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done_w[0]); end
        checks++; if (rd_w[0] !== 1'b0 || wr_w[0] !== 1'b0) begin errors++; $display("FAIL reset_rdwr: got rd=%0b wr=%0b expected 0 0", rd_w[0], wr_w[0]); end
        checks++; if (addr_w[0] !== '0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", addr_w[0]); end
        checks++; if (wdata_w[0] !== '0) begin errors++; $display("FAIL reset_wdata: got %0d expected 0", wdata_w[0]); end
        checks++; if (slice_w[0] !== '0) begin errors++; $display("FAIL reset_slice: got %0d expected 0", slice_w[0]); end
        checks++; if (st_w[0] !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", st_w[0]); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_pi_map();
        bit ok;
        int exp_len = 2;
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    exp_len += 6 + (2*i + 3*j) / 5;
        preload_dut5();
        clear_mon(0);
        pulse_start(0, 1'b0, 2, 3);
        wait_done_cnt(1, 2000, ok);
        repeat (3) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL pi_timeout: got no done expected done within 2000 cycles"); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL pi_done_once: got %0d expected 1", done_cnt); end
        checks++; if (wr_q.size() !== 100) begin errors++; $display("FAIL pi_writes: got %0d expected 100", wr_q.size()); end
        checks++; if (rd_q[24] !== 12'd24) begin errors++; $display("FAIL pi_rd_44: got %0d expected 24", rd_q[24]); end
        checks++; if (wr_q[24] !== 12'(DST + 20)) begin errors++; $display("FAIL pi_wr_44: got %0d expected %0d", wr_q[24], DST + 20); end
        checks++; if (wr_q[6] !== 12'(DST + 5)) begin errors++; $display("FAIL pi_wr_11: got %0d expected %0d", wr_q[6], DST + 5); end
        checks++; if (wr_q[49] !== 12'(DST + 45)) begin errors++; $display("FAIL pi_wr_44_s1: got %0d expected %0d", wr_q[49], DST + 45); end
        checks++; if (rd_cyc_q[24] - rd_cyc_q[23] !== 10) begin errors++; $display("FAIL pi_cell44_latency: got %0d expected 10", rd_cyc_q[24] - rd_cyc_q[23]); end
        checks++; if (count_bad_map(2, 3) !== 0) begin errors++; $display("FAIL pi_contents: got %0d bad cells expected 0", count_bad_map(2, 3)); end
        checks++; if (done_cyc - load_cyc_q[0] + 1 !== exp_len) begin errors++; $display("FAIL pi_run_len: got %0d expected %0d", done_cyc - load_cyc_q[0] + 1, exp_len); end
        checks++; if (fall_cyc !== done_cyc + 1) begin errors++; $display("FAIL pi_busy_fall: got %0d expected %0d", fall_cyc, done_cyc + 1); end
    endtask

    task automatic test_start_ignored();
        bit ok;
        preload_dut5();
        clear_mon(0);
        pulse_start(0, 1'b0, 1, 2);
        repeat (100) @(negedge clk);
        pulse_start(0, 1'b1, 3, 0);
        wait_done_cnt(1, 2000, ok);
        repeat (3) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL ign_timeout: got no done expected done within 2000 cycles"); end
        checks++; if (load_cyc_q.size() !== 1) begin errors++; $display("FAIL ign_no_restart: got %0d loads expected 1", load_cyc_q.size()); end
        checks++; if (wr_q.size() !== 100) begin errors++; $display("FAIL ign_writes: got %0d expected 100", wr_q.size()); end
        checks++; if (count_bad_map(1, 2) !== 0) begin errors++; $display("FAIL ign_contents: got %0d bad cells expected 0", count_bad_map(1, 2)); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int first_done;
        int n = 0;
        clear_mon(0);
        @(negedge clk);
        mode_r[0]  = 1'b0;
        a_r[0]     = 3'd2;
        b_r[0]     = 3'd3;
        start_r[0] = 1'b1;
        wait_done_cnt(1, 2000, ok);
        first_done = done_cyc;
        while (load_cyc_q.size() < 2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        start_r[0] = 1'b0;
        checks++; if (load_cyc_q[1] !== first_done + 2) begin errors++; $display("FAIL b2b_restart_gap: got %0d expected %0d", load_cyc_q[1] - first_done, 2); end
        wait_done_cnt(2, 2000, ok);
        repeat (5) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got no second done expected one within 2000 cycles"); end
        checks++; if (wr_q.size() !== 200) begin errors++; $display("FAIL b2b_writes: got %0d expected 200", wr_q.size()); end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int n = 0;
        clear_mon(0);
        pulse_start(0, 1'b0, 2, 3);
        while (!(slice_w[0] == 2'd3 && st_w[0] == 4'd3) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 2000) begin errors++; $display("FAIL mid_reach_reduce: got timeout expected REDUCE in slice 3"); end
        rst = 1'b1;
        #1;
        checks++; if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b expected 0", busy_w[0]); end
        checks++; if (rd_w[0] !== 1'b0 || wr_w[0] !== 1'b0) begin errors++; $display("FAIL mid_rdwr: got rd=%0b wr=%0b expected 0 0", rd_w[0], wr_w[0]); end
        checks++; if (slice_w[0] !== '0) begin errors++; $display("FAIL mid_slice: got %0d expected 0", slice_w[0]); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_mon(0);
        pulse_start(0, 1'b0, 1, 1);
        wait_done_cnt(1, 2000, ok);
        repeat (3) @(negedge clk);
        checks++; if (rd_q[0] !== '0) begin errors++; $display("FAIL mid_restart_addr: got %0d expected 0", rd_q[0]); end
        checks++; if (wr_q.size() !== 100) begin errors++; $display("FAIL mid_restart_writes: got %0d expected 100", wr_q.size()); end
        checks++; if (wr_q[24] !== 12'(DST + 23)) begin errors++; $display("FAIL mid_new_coefs: got %0d expected %0d", wr_q[24], DST + 23); end
    endtask

    task automatic test_transpose();
        bit ok;
        int bad = 0;
        for (int k = 0; k < 16; k++) begin
            mem[2][k]       = DW'(8'h40 + k);
            mem[2][DST + k] = 8'hEE;
        end
        clear_mon(2);
        pulse_start(2, 1'b1, 5, 6);
        wait_done_cnt(1, 500, ok);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (mem[2][DST + j*4 + i] !== DW'(8'h40 + i*4 + j)) bad++;
        checks++; if (!ok) begin errors++; $display("FAIL tr_timeout: got no done expected done within 500 cycles"); end
        checks++; if (wr_q.size() !== 16) begin errors++; $display("FAIL tr_writes: got %0d expected 16", wr_q.size()); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL tr_contents: got %0d bad cells expected 0", bad); end
        checks++; if (done_cyc - load_cyc_q[0] + 1 !== 82) begin errors++; $display("FAIL tr_run_len: got %0d expected 82", done_cyc - load_cyc_q[0] + 1); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL tr_done_once: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_n1();
        bit ok;
        int bad_addr = 0;
        int bad_data = 0;
        for (int s = 0; s < 4; s++) begin
            mem[1][s]       = DW'(8'hA0 + s);
            mem[1][DST + s] = 8'hEE;
        end
        clear_mon(1);
        pulse_start(1, 1'b0, 7, 7);
        wait_done_cnt(1, 500, ok);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            if (wr_q[s] !== 12'(DST + s)) bad_addr++;
            if (mem[1][DST + s] !== DW'(8'hA0 + s)) bad_data++;
        end
        checks++; if (!ok) begin errors++; $display("FAIL n1_timeout: got no done expected done within 500 cycles"); end
        checks++; if (wr_q.size() !== 4) begin errors++; $display("FAIL n1_writes: got %0d expected 4", wr_q.size()); end
        checks++; if (bad_addr !== 0) begin errors++; $display("FAIL n1_wr_addr: got %0d bad addresses expected 0", bad_addr); end
        checks++; if (bad_data !== 0) begin errors++; $display("FAIL n1_contents: got %0d bad cells expected 0", bad_data); end
        checks++; if (rd_cyc_q[1] - rd_cyc_q[0] !== 6) begin errors++; $display("FAIL n1_cell_latency: got %0d expected 6", rd_cyc_q[1] - rd_cyc_q[0]); end
        checks++; if (done_cyc - load_cyc_q[0] + 1 !== 26) begin errors++; $display("FAIL n1_run_len: got %0d expected 26", done_cyc - load_cyc_q[0] + 1); end
    endtask

    initial begin
        test_reset();
        test_pi_map();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_transpose();
        test_n1();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL rd_wr_exclusive: got %0d overlapping cycles expected 0", both_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
